input_buffer_loader: RTL and testbench

Upstream feeder for the input buffer. On a start command it streams one full input tile, INPUT_HEIGHT rows by INPUT_WIDTH columns, from the input SRAM into the buffer. It issues one SRAM word read per cycle; each word holds INPUT_SRAM_LEN packed elements. Each returned word is written into the buffer one cycle later, with row/column coordinates and a write-enable pulse. Sits between the input SRAM and the input buffer, under control of the layer sequencer.

---
 rtl/input_buffer_loader.sv | 130 +++++++++++++
 tb/tb_input_buffer_loader.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/input_buffer_loader.sv
`timescale 1ns/1ps
// Streams one INPUT_HEIGHT x INPUT_WIDTH tile from the input SRAM into the input
// buffer: one word read per cycle, each returned word written one cycle later.
module input_buffer_loader #(
  parameter int BIN_LEN        = 8,
  parameter int INPUT_HEIGHT   = 8,
  parameter int INPUT_WIDTH    = 8,
  parameter int INPUT_SRAM_LEN = 4,
  parameter int ADDR_W         = 16
) (
  input  logic                              clock,
  input  logic                              reset_n,
  input  logic                              start,
  input  logic [ADDR_W-1:0]                 base_addr,
  input  logic                              hold,
  output logic                              busy,
  output logic                              done,
  output logic                              sram_rd_en,
  output logic [ADDR_W-1:0]                 sram_addr,
  input  logic [BIN_LEN*INPUT_SRAM_LEN-1:0] sram_rdata,
  output logic                              buf_w_enable,
  output logic [BIN_LEN*INPUT_SRAM_LEN-1:0] buf_SRAM_in,
  output logic [$clog2(INPUT_HEIGHT)-1:0]   buf_SRAM_r,
  output logic [$clog2(INPUT_WIDTH)-1:0]    buf_SRAM_c,
  output logic [1:0]                        dbg_state_o
);

  localparam int WPR   = INPUT_WIDTH / INPUT_SRAM_LEN;
  localparam int N     = INPUT_HEIGHT * WPR;
  localparam int W_W   = (N > 1) ? $clog2(N) : 1;
  localparam int ROW_W = $clog2(INPUT_HEIGHT);
  localparam int COL_W = $clog2(INPUT_WIDTH);
  localparam int DW    = BIN_LEN * INPUT_SRAM_LEN;

  localparam logic [W_W-1:0]   W_LAST   = W_W'(N - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(INPUT_WIDTH - INPUT_SRAM_LEN);
  localparam logic [COL_W-1:0] COL_STEP = COL_W'(INPUT_SRAM_LEN);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  base_q, base_d;
  logic [W_W-1:0]     w_q, w_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic [COL_W-1:0]   col_q, col_d;
  logic               rd_valid_q;
  logic [ROW_W-1:0]   wr_row_q;
  logic [COL_W-1:0]   wr_col_q;
  logic [DW-1:0]      data_hold_q;

  // SRAM handshake: sram_rd_en is a one-cycle request with no back-pressure;
  // sram_rdata is valid exactly one cycle later, marked here by rd_valid_q.
  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    w_d        = w_q;
    row_d      = row_q;
    col_d      = col_q;
    sram_rd_en = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          base_d  = base_addr;
          w_d     = '0;
          row_d   = '0;
          col_d   = '0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (!hold) begin
          sram_rd_en = 1'b1;
          w_d        = w_q + 1'b1;
          if (col_q == COL_LAST) begin
            col_d = '0;
            row_d = row_q + 1'b1;
          end else begin
            col_d = col_q + COL_STEP;
          end
          if (w_q == W_LAST) state_d = DRAIN;
        end
      end
      DRAIN:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      base_q      <= '0;
      w_q         <= '0;
      row_q       <= '0;
      col_q       <= '0;
      rd_valid_q  <= 1'b0;
      wr_row_q    <= '0;
      wr_col_q    <= '0;
      data_hold_q <= '0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      w_q        <= w_d;
      row_q      <= row_d;
      col_q      <= col_d;
      rd_valid_q <= sram_rd_en;
      // Coordinates and data only move on real traffic so idle outputs stay stable.
      if (sram_rd_en) begin
        wr_row_q <= row_q;
        wr_col_q <= col_q;
      end
      if (rd_valid_q) data_hold_q <= sram_rdata;
    end
  end

  assign sram_addr    = sram_rd_en ? (base_q + ADDR_W'(w_q)) : '0;
  assign busy         = (state_q == ISSUE) || (state_q == DRAIN);
  assign done         = (state_q == DONE);
  assign buf_w_enable = rd_valid_q;
  assign buf_SRAM_in  = rd_valid_q ? sram_rdata : data_hold_q;
  assign buf_SRAM_r   = wr_row_q;
  assign buf_SRAM_c   = wr_col_q;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_input_buffer_loader.sv
`timescale 1ns/1ps
// Directed bench for input_buffer_loader: SRAM echo model, buffer model and a
// cycle-level model of the load schedule, one task per scenario.
module tb_input_buffer_loader;

  typedef struct packed {
    logic        rd;
    logic [15:0] addr;
    logic        wen;
    logic [2:0]  r;
    logic [2:0]  c;
    logic [31:0] data;
    logic        busy;
    logic        done;
  } obs_t;

  logic        clock;
  logic        reset_n;
  logic        start;
  logic [15:0] base_addr;
  logic        hold;
  logic        busy, done, sram_rd_en, buf_w_enable;
  logic [15:0] sram_addr;
  logic [31:0] sram_rdata, buf_SRAM_in;
  logic [2:0]  buf_SRAM_r, buf_SRAM_c;
  logic [1:0]  dbg_state_o;

  int errors = 0;
  int checks = 0;

  obs_t        log_a [0:63];
  obs_t        exp_a [0:63];
  logic [7:0]  bufm  [0:7][0:7];
  logic [31:0] exp_q [$];
  logic [2:0]  mlast_r;
  logic [2:0]  mlast_c;
  logic [31:0] mlast_d;

  input_buffer_loader dut (
    .clock(clock), .reset_n(reset_n), .start(start), .base_addr(base_addr),
    .hold(hold), .busy(busy), .done(done), .sram_rd_en(sram_rd_en),
    .sram_addr(sram_addr), .sram_rdata(sram_rdata), .buf_w_enable(buf_w_enable),
    .buf_SRAM_in(buf_SRAM_in), .buf_SRAM_r(buf_SRAM_r), .buf_SRAM_c(buf_SRAM_c),
    .dbg_state_o(dbg_state_o)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  function automatic logic [31:0] word(input logic [15:0] a);
    return {a ^ 16'h5A5A, a};
  endfunction

  // SRAM model: registered read, garbage when not reading.
  always @(posedge clock) sram_rdata <= sram_rd_en ? word(sram_addr) : 32'hDEADBEEF;

  initial begin
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) bufm[r][c] = 8'h00;
  end

  always @(posedge clock)
    if (buf_w_enable === 1'b1)
      for (int k = 0; k < 4; k++) bufm[buf_SRAM_r][buf_SRAM_c + k] <= buf_SRAM_in[k*8 +: 8];

  // ---------------- driver ----------------
  // Called just after a rising edge; cycle k of the run is the k-th interval.
  task automatic run(input int ncyc, input logic [15:0] base, input logic [63:0] smask,
                     input logic [63:0] hmask);
    obs_t o;
    base_addr = base;
    for (int k = 0; k < ncyc; k++) begin
      start = smask[k];
      hold  = hmask[k];
      @(negedge clock);
      o.rd   = sram_rd_en;
      o.addr = sram_rd_en ? sram_addr : 16'h0;
      o.wen  = buf_w_enable;
      o.r    = buf_SRAM_r;
      o.c    = buf_SRAM_c;
      o.data = buf_SRAM_in;
      o.busy = busy;
      o.done = done;
      log_a[k] = o;
      @(posedge clock);
      #1;
    end
    start = 1'b0;
    hold  = 1'b0;
  endtask

  // Cycle-level model of the load schedule.
  task automatic build_exp(input int ncyc, input logic [15:0] base, input logic [63:0] smask,
                           input logic [63:0] hmask);
    obs_t        e;
    int          st, w, pw;
    bit          pend;
    logic [15:0] b;
    st = 0; w = 0; pw = 0; pend = 0; b = 16'h0;
    for (int k = 0; k < ncyc; k++) begin
      e = '0;
      e.r = mlast_r; e.c = mlast_c; e.data = mlast_d;
      if (pend) begin
        e.wen = 1'b1;
        e.r = 3'(pw / 2);
        e.c = 3'((pw % 2) * 4);
        e.data = word(b + 16'(pw));
        mlast_r = e.r; mlast_c = e.c; mlast_d = e.data;
      end
      pend = 0;
      case (st)
        0: if (smask[k]) begin b = base; w = 0; st = 1; end
        1: begin
          e.busy = 1'b1;
          if (!hmask[k]) begin
            e.rd = 1'b1; e.addr = b + 16'(w);
            pend = 1; pw = w; w++;
            if (w == 16) st = 2;
          end
        end
        2: begin e.busy = 1'b1; st = 3; end
        default: begin e.done = 1'b1; st = 0; end
      endcase
      exp_a[k] = e;
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset_n = 1'b0; start = 1'b0; hold = 1'b0; base_addr = 16'h0;
    repeat (2) @(posedge clock);
    #1;
    checks++;
    if ({busy, done, sram_rd_en, buf_w_enable} !== 4'b0000) begin
      errors++; $display("FAIL reset_ctrl got=%b exp=0000", {busy, done, sram_rd_en, buf_w_enable});
    end
    checks++;
    if (sram_addr !== 16'h0) begin errors++; $display("FAIL reset_addr got=%h exp=0000", sram_addr); end
    checks++;
    if ({buf_SRAM_in, buf_SRAM_r, buf_SRAM_c} !== 38'h0) begin
      errors++; $display("FAIL reset_buf got=%h/%0d/%0d exp=0/0/0", buf_SRAM_in, buf_SRAM_r, buf_SRAM_c);
    end
    checks++;
    if (dbg_state_o !== 2'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", dbg_state_o); end
    reset_n = 1'b1;
    mlast_r = 3'd0; mlast_c = 3'd0; mlast_d = 32'h0;
    @(posedge clock);
    #1;
  endtask

  task automatic test_basic();
    int nw;
    logic [31:0] wd;
    build_exp(20, 16'h0100, 64'h1, 64'h0);
    run(20, 16'h0100, 64'h1, 64'h0);
    for (int k = 0; k < 20; k++) begin
      checks++;
      if (log_a[k] !== exp_a[k]) begin
        errors++; $display("FAIL basic_cyc%0d got=%h exp=%h", k, log_a[k], exp_a[k]);
      end
    end
    nw = 0;
    for (int k = 0; k < 20; k++) nw += int'(log_a[k].wen);
    checks++;
    if (nw != 16) begin errors++; $display("FAIL basic_writes got=%0d exp=16", nw); end
    checks++;
    if (log_a[16].rd !== 1'b1 || log_a[16].addr !== 16'h010F) begin
      errors++; $display("FAIL basic_last_read got=%b/%h exp=1/010f", log_a[16].rd, log_a[16].addr);
    end
    checks++;
    if ({log_a[17].wen, log_a[17].r, log_a[17].c} !== {1'b1, 3'd7, 3'd4}) begin
      errors++; $display("FAIL basic_last_write got=%b/%0d/%0d exp=1/7/4", log_a[17].wen, log_a[17].r, log_a[17].c);
    end
    checks++;
    if ({log_a[17].busy, log_a[18].busy, log_a[18].done, log_a[17].done} !== 4'b1010) begin
      errors++; $display("FAIL basic_done got=%b exp=1010", {log_a[17].busy, log_a[18].busy, log_a[18].done, log_a[17].done});
    end
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) begin
        wd = word(16'h0100 + 16'(r * 2 + c / 4));
        checks++;
        if (bufm[r][c] !== wd[(c % 4)*8 +: 8]) begin
          errors++; $display("FAIL basic_buf(%0d,%0d) got=%h exp=%h", r, c, bufm[r][c], wd[(c % 4)*8 +: 8]);
        end
      end
  endtask

  task automatic test_hold();
    int nw;
    logic [31:0] a;
    build_exp(24, 16'h0100, 64'h1, 64'hE0);
    run(24, 16'h0100, 64'h1, 64'hE0);
    for (int k = 0; k < 24; k++) begin
      checks++;
      if (log_a[k] !== exp_a[k]) begin
        errors++; $display("FAIL hold_cyc%0d got=%h exp=%h", k, log_a[k], exp_a[k]);
      end
    end
    checks++;
    if ({log_a[5].rd, log_a[6].rd, log_a[7].rd, log_a[8].rd} !== 4'b0001) begin
      errors++; $display("FAIL hold_gap got=%b exp=0001", {log_a[5].rd, log_a[6].rd, log_a[7].rd, log_a[8].rd});
    end
    checks++;
    if (log_a[21].done !== 1'b1 || log_a[18].done !== 1'b0) begin
      errors++; $display("FAIL hold_done got=%b%b exp=10", log_a[21].done, log_a[18].done);
    end
    exp_q.delete();
    for (int i = 0; i < 16; i++) exp_q.push_back(32'(16'h0100 + 16'(i)));
    nw = 0;
    for (int k = 0; k < 24; k++) begin
      nw += int'(log_a[k].wen);
      if (log_a[k].rd === 1'b1) begin
        a = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hFFFFFFFF;
        checks++;
        if (32'(log_a[k].addr) !== a) begin
          errors++; $display("FAIL hold_addr_seq cyc%0d got=%h exp=%h", k, log_a[k].addr, a);
        end
      end
    end
    checks++;
    if (exp_q.size() != 0 || nw != 16) begin
      errors++; $display("FAIL hold_counts left=%0d writes=%0d exp=0/16", exp_q.size(), nw);
    end
  endtask

  task automatic test_wrap();
    build_exp(20, 16'hFFFA, 64'h1, 64'h0);
    run(20, 16'hFFFA, 64'h1, 64'h0);
    for (int k = 0; k < 20; k++) begin
      checks++;
      if (log_a[k] !== exp_a[k]) begin
        errors++; $display("FAIL wrap_cyc%0d got=%h exp=%h", k, log_a[k], exp_a[k]);
      end
    end
    checks++;
    if ({log_a[6].addr, log_a[7].addr, log_a[16].addr} !== {16'hFFFF, 16'h0000, 16'h0009}) begin
      errors++; $display("FAIL wrap_addr got=%h %h %h exp=ffff 0000 0009", log_a[6].addr, log_a[7].addr, log_a[16].addr);
    end
    checks++;
    if ({log_a[8].wen, log_a[8].r, log_a[8].c, log_a[8].data} !== {1'b1, 3'd3, 3'd0, 32'h5A5A0000}) begin
      errors++; $display("FAIL wrap_write got=%b/%0d/%0d/%h exp=1/3/0/5a5a0000", log_a[8].wen, log_a[8].r, log_a[8].c, log_a[8].data);
    end
  endtask

  task automatic test_start_ignored();
    logic [63:0] sm;
    sm = 64'h1 | (64'h1 << 3) | (64'h1 << 18) | (64'h1 << 19);
    build_exp(40, 16'h0200, sm, 64'h0);
    run(40, 16'h0200, sm, 64'h0);
    for (int k = 0; k < 40; k++) begin
      checks++;
      if (log_a[k] !== exp_a[k]) begin
        errors++; $display("FAIL restart_cyc%0d got=%h exp=%h", k, log_a[k], exp_a[k]);
      end
    end
    checks++;
    if ({log_a[4].addr, log_a[18].done, log_a[19].rd, log_a[20].rd, log_a[20].addr} !== {16'h0203, 1'b1, 1'b0, 1'b1, 16'h0200}) begin
      errors++; $display("FAIL restart_points got=%h %b %b %b %h exp=0203 1 0 1 0200",
                         log_a[4].addr, log_a[18].done, log_a[19].rd, log_a[20].rd, log_a[20].addr);
    end
    checks++;
    if (log_a[37].done !== 1'b1) begin errors++; $display("FAIL restart_done2 got=%b exp=1", log_a[37].done); end
  endtask

  task automatic test_mid_reset();
    logic [31:0] wd;
    run(8, 16'h0300, 64'h1, 64'h0);
    reset_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, sram_rd_en, buf_w_enable} !== 4'b0000) begin
      errors++; $display("FAIL midrst_ctrl got=%b exp=0000", {busy, done, sram_rd_en, buf_w_enable});
    end
    checks++;
    if ({sram_addr, buf_SRAM_in, buf_SRAM_r, buf_SRAM_c} !== 54'h0) begin
      errors++; $display("FAIL midrst_data got=%h/%h/%0d/%0d exp=0", sram_addr, buf_SRAM_in, buf_SRAM_r, buf_SRAM_c);
    end
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      checks++;
      if ({sram_rd_en, buf_w_enable, busy, done, dbg_state_o} !== 6'b0) begin
        errors++; $display("FAIL midrst_quiet%0d got=%b exp=000000", k, {sram_rd_en, buf_w_enable, busy, done, dbg_state_o});
      end
      @(posedge clock);
      #1;
    end
    mlast_r = 3'd0; mlast_c = 3'd0; mlast_d = 32'h0;
    build_exp(20, 16'h0400, 64'h1, 64'h0);
    run(20, 16'h0400, 64'h1, 64'h0);
    for (int k = 0; k < 20; k++) begin
      checks++;
      if (log_a[k] !== exp_a[k]) begin
        errors++; $display("FAIL reload_cyc%0d got=%h exp=%h", k, log_a[k], exp_a[k]);
      end
    end
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) begin
        wd = word(16'h0400 + 16'(r * 2 + c / 4));
        checks++;
        if (bufm[r][c] !== wd[(c % 4)*8 +: 8]) begin
          errors++; $display("FAIL reload_buf(%0d,%0d) got=%h exp=%h", r, c, bufm[r][c], wd[(c % 4)*8 +: 8]);
        end
      end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    test_reset();
    test_basic();
    test_hold();
    test_wrap();
    test_start_ignored();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
